// File: rtl/rsff_cmd_driver_if.sv
// Request handshake between control logic and rsff_cmd_driver.
//   req_valid  request present (master -> slave)
//   req_op     00 nop, 01 clear, 10 set, 11 toggle (master -> slave)
//   req_ready  driver can accept a request (slave -> master)
interface rsff_cmd_driver_if;
  logic       req_valid;
  logic [1:0] req_op;
  logic       req_ready;

  modport master (
    output req_valid,
    output req_op,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_op,
    output req_ready
  );
endinterface

// File: rtl/rsff_cmd_driver.sv
// Command-side driver for a clocked RS flip-flop. Accepts set/clear/toggle requests, holds the
// RS code for HOLD_CYCLES clocks (0 treated as 1), releases for one clock, and tracks the
// expected flip-flop state. The illegal RS code 3 is never produced.
//
// Optional feature macro: RSFF_FB_CHECK_EN adds a CHECK state that compares q_fb against
// exp_q after every command and sets the sticky err flag on mismatch. Without it, q_fb and
// err_clr are unused and err is tied to 0.
//
// Ports:
//   clk      rising-edge clock, shared with the flip-flop
//   rst      asynchronous active-high reset
//   req      request handshake (slave modport): req_valid, req_op, req_ready
//   rs       RS code to the flip-flop: 0 hold, 1 clear, 2 set
//   q_fb     flip-flop q feedback (check feature only)
//   err_clr  clears sticky err (check feature only)
//   done     one-cycle pulse when a command completes
//   busy     high whenever the state is not idle
//   exp_q    expected flip-flop state
//   err      sticky feedback-mismatch flag
module rsff_cmd_driver #(
  parameter int unsigned HOLD_CYCLES = 2,
  parameter int unsigned CNT_W       = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  rsff_cmd_driver_if.slave     req,
  output logic [1:0]           rs,
  input  logic                 q_fb,
  input  logic                 err_clr,
  output logic                 done,
  output logic                 busy,
  output logic                 exp_q,
  output logic                 err
);

  localparam int unsigned     Hold     = (HOLD_CYCLES == 0) ? 1 : HOLD_CYCLES;
  localparam logic [CNT_W-1:0] HoldLast = CNT_W'(Hold - 1);

  localparam logic [1:0] RsHold = 2'd0;
  localparam logic [1:0] RsClr  = 2'd1;
  localparam logic [1:0] RsSet  = 2'd2;

`ifdef RSFF_FB_CHECK_EN
  typedef enum logic [1:0] {StIdle, StDrive, StRelease, StCheck} state_e;
`else
  typedef enum logic [1:0] {StIdle, StDrive, StRelease} state_e;
`endif

  state_e           state_q, state_d;
  logic [1:0]       rs_q, rs_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ready_q, ready_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             expq_q, expq_d;
  logic             expv_q, expv_d;
  logic [1:0]       acc_code;

`ifdef RSFF_FB_CHECK_EN
  logic             err_q, err_d;
  logic             mismatch;
`endif

  // Resolve the requested op into an RS code; toggle needs a known prior state to flip.
  always_comb begin
    acc_code = RsHold;
    case (req.req_op)
      2'b01:   acc_code = RsClr;
      2'b10:   acc_code = RsSet;
      2'b11:   acc_code = (expv_q && expq_q) ? RsClr : RsSet;
      default: acc_code = RsHold;
    endcase
  end

  always_comb begin
    state_d = state_q;
    rs_d    = rs_q;
    cnt_d   = cnt_q;
    ready_d = ready_q;
    done_d  = 1'b0;
    busy_d  = busy_q;
    expq_d  = expq_q;
    expv_d  = expv_q;
`ifdef RSFF_FB_CHECK_EN
    mismatch = 1'b0;
`endif
    case (state_q)
      StIdle: begin
        if (req.req_valid && ready_q) begin
          if (acc_code == RsHold) begin
            done_d = 1'b1;
          end else begin
            state_d = StDrive;
            rs_d    = acc_code;
            cnt_d   = HoldLast;
            ready_d = 1'b0;
            busy_d  = 1'b1;
            expq_d  = (acc_code == RsSet);
            expv_d  = 1'b1;
          end
        end
      end
      StDrive: begin
        if (cnt_q == '0) begin
          state_d = StRelease;
          rs_d    = RsHold;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StRelease: begin
`ifdef RSFF_FB_CHECK_EN
        state_d = StCheck;
`else
        state_d = StIdle;
        done_d  = 1'b1;
        ready_d = 1'b1;
        busy_d  = 1'b0;
`endif
      end
`ifdef RSFF_FB_CHECK_EN
      StCheck: begin
        state_d  = StIdle;
        done_d   = 1'b1;
        ready_d  = 1'b1;
        busy_d   = 1'b0;
        mismatch = (q_fb != expq_q);
      end
`endif
      default: begin
        state_d = StIdle;
        rs_d    = RsHold;
        ready_d = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

`ifdef RSFF_FB_CHECK_EN
  // A mismatch in the same cycle as err_clr keeps err set.
  always_comb begin
    err_d = err_q;
    if (err_clr)  err_d = 1'b0;
    if (mismatch) err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  logic unused_fb;
  assign unused_fb = q_fb ^ err_clr;
  assign err       = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      rs_q    <= RsHold;
      cnt_q   <= '0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      expq_q  <= 1'b0;
      expv_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rs_q    <= rs_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      expq_q  <= expq_d;
      expv_q  <= expv_d;
    end
  end

  assign req.req_ready = ready_q;
  assign rs            = rs_q;
  assign done          = done_q;
  assign busy          = busy_q;
  assign exp_q         = expq_q;

endmodule

// File: tb/tb_rsff_cmd_driver.sv
module tb_rsff_cmd_driver;

  localparam int H  = 2;
  localparam int H0 = 1;  // HOLD_CYCLES=0 behaves as 1
`ifdef RSFF_FB_CHECK_EN
  localparam int L  = H + 2;
  localparam int L0 = H0 + 2;
`else
  localparam int L  = H + 1;
  localparam int L0 = H0 + 1;
`endif

  localparam logic [1:0] OP_NOP = 2'b00;
  localparam logic [1:0] OP_CLR = 2'b01;
  localparam logic [1:0] OP_SET = 2'b10;
  localparam logic [1:0] OP_TOG = 2'b11;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       q_fb = 1'b0;
  logic       err_clr = 1'b0;
  logic [1:0] rs, rs0;
  logic       done, busy, exp_q, err;
  logic       done0, busy0, exp_q0, err0;

  rsff_cmd_driver_if bus ();
  rsff_cmd_driver_if bus0 ();

  rsff_cmd_driver #(.HOLD_CYCLES(H), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .req(bus.slave), .rs(rs), .q_fb(q_fb), .err_clr(err_clr),
    .done(done), .busy(busy), .exp_q(exp_q), .err(err)
  );

  rsff_cmd_driver #(.HOLD_CYCLES(0), .CNT_W(4)) dut0 (
    .clk(clk), .rst(rst), .req(bus0.slave), .rs(rs0), .q_fb(1'b1), .err_clr(1'b0),
    .done(done0), .busy(busy0), .exp_q(exp_q0), .err(err0)
  );

  always #5 clk = ~clk;

  int nchk = 0;
  int nerr = 0;

  // Reference model: what the flip-flop should hold and whether that is known.
  logic m_q = 1'b0;
  logic m_valid = 1'b0;

  logic [1:0] tr_rs   [0:7];
  logic       tr_done [0:7];
  logic       tr_busy [0:7];
  logic       tr_ready[0:7];
  logic       tr_err  [0:7];

  function automatic logic [1:0] model_code(input logic [1:0] op);
    case (op)
      OP_CLR:  return 2'd1;
      OP_SET:  return 2'd2;
      OP_TOG:  return (m_valid && m_q) ? 2'd1 : 2'd2;
      default: return 2'd0;
    endcase
  endfunction

  task automatic model_update(input logic [1:0] op);
    logic [1:0] c;
    c = model_code(op);
    if (c != 2'd0) begin
      m_q     = (c == 2'd2);
      m_valid = 1'b1;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.req_valid  = 1'b0;
    bus.req_op     = OP_NOP;
    bus0.req_valid = 1'b0;
    bus0.req_op    = OP_NOP;
    err_clr        = 1'b0;
    rst            = 1'b1;
    step();
    rst     = 1'b0;
    m_q     = 1'b0;
    m_valid = 1'b0;
  endtask

  // Issue one request while idle and record outputs for 8 cycles after the accepting edge.
  task automatic capture(input logic [1:0] op, input int clr_at);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    step();
    bus.req_valid = 1'b0;
    bus.req_op    = 2'($urandom);
    for (int k = 0; k < 8; k++) begin
      tr_rs[k]    = rs;
      tr_done[k]  = done;
      tr_busy[k]  = busy;
      tr_ready[k] = bus.req_ready;
      tr_err[k]   = err;
      err_clr     = (k == clr_at);
      step();
    end
    err_clr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_op = OP_NOP;
    bus0.req_valid = 1'b0;
    bus0.req_op = OP_NOP;
    step();
    nchk++; if (rs !== 2'd0) begin nerr++; $display("FAIL reset_rs: got %0d want 0", rs); end
    nchk++; if (bus.req_ready !== 1'b1) begin
      nerr++; $display("FAIL reset_ready: got %b want 1", bus.req_ready);
    end
    nchk++; if (done !== 1'b0) begin nerr++; $display("FAIL reset_done: got %b want 0", done); end
    nchk++; if (busy !== 1'b0) begin nerr++; $display("FAIL reset_busy: got %b want 0", busy); end
    nchk++; if (exp_q !== 1'b0) begin nerr++; $display("FAIL reset_expq: got %b want 0", exp_q); end
    nchk++; if (err !== 1'b0) begin nerr++; $display("FAIL reset_err: got %b want 0", err); end
    rst = 1'b0;
    m_q = 1'b0;
    m_valid = 1'b0;
  endtask

  task automatic test_set();
    logic [1:0] c;
    do_reset();
    c = model_code(OP_SET);
    model_update(OP_SET);
    q_fb = m_q;
    capture(OP_SET, -1);
    for (int k = 0; k <= L; k++) begin
      nchk++; if (tr_rs[k] !== ((k < H) ? c : 2'd0)) begin
        nerr++; $display("FAIL set_rs[%0d]: got %0d want %0d", k, tr_rs[k], (k < H) ? c : 2'd0);
      end
      nchk++; if (tr_done[k] !== (k == L)) begin
        nerr++; $display("FAIL set_done[%0d]: got %b want %b", k, tr_done[k], k == L);
      end
      nchk++; if (tr_busy[k] !== (k < L)) begin
        nerr++; $display("FAIL set_busy[%0d]: got %b want %b", k, tr_busy[k], k < L);
      end
      nchk++; if (tr_ready[k] !== (k == L)) begin
        nerr++; $display("FAIL set_ready[%0d]: got %b want %b", k, tr_ready[k], k == L);
      end
    end
    nchk++; if (exp_q !== m_q) begin nerr++; $display("FAIL set_expq: got %b want %b", exp_q, m_q); end
  endtask

  task automatic test_toggle();
    logic [1:0] c;
    do_reset();
    for (int n = 0; n < 2; n++) begin
      c = model_code(OP_TOG);
      model_update(OP_TOG);
      q_fb = m_q;
      capture(OP_TOG, -1);
      for (int k = 0; k <= L; k++) begin
        nchk++; if (tr_rs[k] !== ((k < H) ? c : 2'd0)) begin
          nerr++; $display("FAIL tog%0d_rs[%0d]: got %0d want %0d", n, k, tr_rs[k], (k < H) ? c : 2'd0);
        end
      end
      nchk++; if (exp_q !== m_q) begin
        nerr++; $display("FAIL tog%0d_expq: got %b want %b", n, exp_q, m_q);
      end
    end
  endtask

  task automatic test_nop();
    logic prev_q;
    prev_q = m_q;
    capture(OP_NOP, -1);
    for (int k = 0; k < 8; k++) begin
      nchk++; if (tr_rs[k] !== 2'd0) begin
        nerr++; $display("FAIL nop_rs[%0d]: got %0d want 0", k, tr_rs[k]);
      end
      nchk++; if (tr_done[k] !== (k == 0)) begin
        nerr++; $display("FAIL nop_done[%0d]: got %b want %b", k, tr_done[k], k == 0);
      end
    end
    nchk++; if (exp_q !== prev_q) begin nerr++; $display("FAIL nop_expq: got %b want %b", exp_q, prev_q); end
  endtask

  task automatic test_back_to_back();
    logic [1:0] c1, c2, want;
    logic [1:0] b_rs  [0:15];
    logic       b_done[0:15];
    int         n;
    do_reset();
    c1 = model_code(OP_CLR);
    model_update(OP_CLR);
    c2 = model_code(OP_SET);
    model_update(OP_SET);
    n = 2 * L + 4;
    q_fb = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_op    = OP_CLR;
    step();
    bus.req_op = OP_SET;
    for (int k = 0; k < n; k++) begin
      b_rs[k]   = rs;
      b_done[k] = done;
      if (k == L + 1) begin
        bus.req_valid = 1'b0;
        q_fb = 1'b1;
      end
      step();
    end
    for (int k = 0; k < n; k++) begin
      if (k < H) want = c1;
      else if (k <= L) want = 2'd0;
      else if (k - (L + 1) < H) want = c2;
      else want = 2'd0;
      nchk++; if (b_rs[k] !== want) begin
        nerr++; $display("FAIL b2b_rs[%0d]: got %0d want %0d", k, b_rs[k], want);
      end
      nchk++; if (b_done[k] !== (k == L || k == 2 * L + 1)) begin
        nerr++; $display("FAIL b2b_done[%0d]: got %b want %b", k, b_done[k], k == L || k == 2 * L + 1);
      end
    end
    nchk++; if (exp_q !== m_q) begin nerr++; $display("FAIL b2b_expq: got %b want %b", exp_q, m_q); end
  endtask

`ifdef RSFF_FB_CHECK_EN
  task automatic test_err();
    do_reset();
    model_update(OP_SET);
    q_fb = 1'b0;  // flip-flop stuck low
    capture(OP_SET, -1);
    nchk++; if (tr_err[L - 1] !== 1'b0) begin nerr++; $display("FAIL err_early: got %b want 0", tr_err[L - 1]); end
    nchk++; if (tr_err[L] !== 1'b1) begin nerr++; $display("FAIL err_set: got %b want 1", tr_err[L]); end
    model_update(OP_SET);
    q_fb = m_q;
    capture(OP_SET, -1);
    nchk++; if (err !== 1'b1) begin nerr++; $display("FAIL err_sticky: got %b want 1", err); end
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    nchk++; if (err !== 1'b0) begin nerr++; $display("FAIL err_clear: got %b want 0", err); end
    model_update(OP_CLR);
    q_fb = 1'b1;  // stuck high, mismatch coincides with err_clr
    capture(OP_CLR, L - 1);
    nchk++; if (tr_err[L] !== 1'b1) begin nerr++; $display("FAIL err_clr_vs_mismatch: got %b want 1", tr_err[L]); end
  endtask
`else
  task automatic test_err();
    do_reset();
    model_update(OP_SET);
    q_fb = 1'b0;
    capture(OP_SET, L - 1);
    for (int k = 0; k < 8; k++) begin
      nchk++; if (tr_err[k] !== 1'b0) begin nerr++; $display("FAIL err_tied[%0d]: got %b want 0", k, tr_err[k]); end
    end
    nchk++; if (tr_done[L] !== 1'b1) begin nerr++; $display("FAIL err_done: got %b want 1", tr_done[L]); end
  endtask
`endif

  task automatic test_reset_mid();
    logic [1:0] c;
    do_reset();
    bus.req_valid = 1'b1;
    bus.req_op    = OP_SET;
    step();
    bus.req_valid = 1'b0;
    nchk++; if (rs !== 2'd2) begin nerr++; $display("FAIL mid_drive_rs: got %0d want 2", rs); end
    #2;
    rst = 1'b1;
    #1;
    nchk++; if (rs !== 2'd0) begin nerr++; $display("FAIL mid_async_rs: got %0d want 0", rs); end
    nchk++; if (busy !== 1'b0) begin nerr++; $display("FAIL mid_async_busy: got %b want 0", busy); end
    step();
    rst = 1'b0;
    m_q = 1'b0;
    m_valid = 1'b0;
    for (int k = 0; k < L + 2; k++) begin
      nchk++; if (done !== 1'b0) begin nerr++; $display("FAIL mid_done[%0d]: got %b want 0", k, done); end
      step();
    end
    c = model_code(OP_TOG);
    model_update(OP_TOG);
    q_fb = m_q;
    capture(OP_TOG, -1);
    nchk++; if (tr_rs[0] !== c) begin nerr++; $display("FAIL mid_toggle_rs: got %0d want %0d", tr_rs[0], c); end
  endtask

  task automatic test_random();
    logic [1:0] op, c;
    do_reset();
    for (int n = 0; n < 30; n++) begin
      op = 2'($urandom_range(0, 3));
      c  = model_code(op);
      model_update(op);
      q_fb = m_q;
      capture(op, -1);
      for (int k = 0; k <= L; k++) begin
        if (c == 2'd0) begin
          nchk++; if (tr_rs[k] !== 2'd0 || tr_done[k] !== (k == 0)) begin
            nerr++; $display("FAIL rnd%0d_nop[%0d]: rs=%0d done=%b want rs=0 done=%b", n, k, tr_rs[k],
                             tr_done[k], k == 0);
          end
        end else begin
          nchk++; if (tr_rs[k] !== ((k < H) ? c : 2'd0) || tr_done[k] !== (k == L)) begin
            nerr++; $display("FAIL rnd%0d_op%0d[%0d]: rs=%0d done=%b want rs=%0d done=%b", n, op, k,
                             tr_rs[k], tr_done[k], (k < H) ? c : 2'd0, k == L);
          end
        end
      end
      nchk++; if (exp_q !== m_q || err !== 1'b0) begin
        nerr++; $display("FAIL rnd%0d_state: expq=%b err=%b want expq=%b err=0", n, exp_q, err, m_q);
      end
    end
  endtask

  task automatic test_hold_zero();
    do_reset();
    bus0.req_valid = 1'b1;
    bus0.req_op    = OP_SET;
    step();
    bus0.req_valid = 1'b0;
    for (int k = 0; k <= L0; k++) begin
      nchk++; if (rs0 !== ((k < H0) ? 2'd2 : 2'd0)) begin
        nerr++; $display("FAIL hold0_rs[%0d]: got %0d want %0d", k, rs0, (k < H0) ? 2'd2 : 2'd0);
      end
      nchk++; if (done0 !== (k == L0)) begin
        nerr++; $display("FAIL hold0_done[%0d]: got %b want %b", k, done0, k == L0);
      end
      step();
    end
    nchk++; if (exp_q0 !== 1'b1 || err0 !== 1'b0) begin
      nerr++; $display("FAIL hold0_state: expq=%b err=%b want expq=1 err=0", exp_q0, err0);
    end
  endtask

  initial begin
    test_reset();
    test_set();
    test_toggle();
    test_nop();
    test_back_to_back();
    test_err();
    test_reset_mid();
    test_random();
    test_hold_zero();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/rsff_cmd_driver.md
# rsff_cmd_driver

Command-side driver for the team's clocked RS flip-flop: accepts set/clear/toggle requests over a valid/ready handshake and produces the 2-bit RS code that drives the flip-flop's `RS` input. Never emits the illegal code 2'd3, holds each command for a programmable number of clocks, tracks the expected flip-flop state, and optionally checks the flip-flop's `q` feedback after every command. Sits between control logic and one RS flip-flop instance, on the same clock.

## Interface
- `HOLD_CYCLES`, 2: clocks each set/clear code is held on `rs`; 0 is treated as 1.
- `CNT_W`, 4: width of the hold counter; `HOLD_CYCLES` must fit in `CNT_W` bits.

- `clk`  in  1  rising-edge clock, shared with the RS flip-flop.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_op`  in  2  00 nop, 01 clear, 10 set, 11 toggle.
- `req_ready`  out  1  driver can accept a request.
- `rs`  out  2  RS code to the flip-flop: 0 hold, 1 clear, 2 set. Never 3.
- `q_fb`  in  1  flip-flop `q` feedback, used only with the check feature.
- `err_clr`  in  1  clears sticky `err`.
- `done`  out  1  one-cycle pulse when a command completes.
- `busy`  out  1  high whenever the state is not IDLE.
- `exp_q`  out  1  expected flip-flop state.
- `err`  out  1  sticky feedback-mismatch flag.

## Operation
- All outputs are registered. Reset values: `rs`=0, `req_ready`=1, `done`=0, `busy`=0, `exp_q`=0, `err`=0. Internal `exp_valid`=0 and state=IDLE.
- States: IDLE, DRIVE, RELEASE, CHECK.
  - CHECK exists only with `RSFF_FB_CHECK_EN`.
- IDLE: `req_ready`=1, `rs`=0. A request is accepted when `req_valid` and `req_ready` are both high at a rising edge.
- Op decoding at acceptance:
  - clear: code 1, `exp_q`←0.
  - set: code 2, `exp_q`←1.
  - toggle: if `exp_valid`, code 1 when `exp_q`=1 and code 2 when `exp_q`=0. If `exp_valid`=0, resolves to set.
  - `exp_valid`←1 on any set, clear or toggle.
  - nop: no state change; stays in IDLE; `done` pulses the next cycle; `rs` stays 0.
- DRIVE: `rs` holds the code and the counter counts HOLD_CYCLES clocks, then the state moves to RELEASE.
- RELEASE: `rs`=0 for one clock. Then CHECK if the feature is compiled in, otherwise IDLE with a `done` pulse.
- CHECK: `q_fb` is sampled at the exit edge. A mismatch against `exp_q` sets `err`. The state returns to IDLE with a `done` pulse.
- `err_clr` clears `err` at the next edge. If `err_clr` and a new mismatch occur in the same cycle, the mismatch wins and `err` stays 1.
- `req_op` is captured only at acceptance. Changes while busy are ignored.
- Asynchronous `rst` mid-command: `rs` returns to 0 immediately, the command is abandoned, no `done` is generated, and `exp_valid` is cleared.

## Timing
- Edge E0 accepts the request.
- After E0: DRIVE, `rs`=code, `req_ready`=0, `busy`=1.
- After E0+H (H = max(HOLD_CYCLES,1)): RELEASE, `rs`=0.
- Without check: after E0+H+1 the state is IDLE, `done`=1 for that cycle, `req_ready`=1. Latency is H+1 clocks.
- With check:
  - After E0+H+1: CHECK.
  - At E0+H+2: `q_fb` sampled.
  - After E0+H+2: IDLE, `done`=1, `err` updated. Latency is H+2 clocks.
- A new request can be accepted in the same cycle that `done` is high. Back-to-back commands are separated by at least one `rs`=0 cycle.
- `q_fb` seen in CHECK reflects the flip-flop update from the last DRIVE edge, so a correct flip-flop never produces a false mismatch.

## Configuration
- `RSFF_FB_CHECK_EN` defined: CHECK state and `q_fb` comparison are present; `err` is functional.
- `RSFF_FB_CHECK_EN` undefined:
  - No CHECK state; `q_fb` and `err_clr` are unused.
  - `err` is tied to 0.
  - Latency is H+1.

## Test plan
- Reset, then set with HOLD_CYCLES=2 → `rs`=2 for 2 cycles, then 0. `exp_q`=1. `done` pulses 3 cycles after acceptance (4 with check).
- Toggle straight after reset → resolves to set (`rs`=2). A second toggle → `rs`=1 and `exp_q`=0.
- Check enabled, `q_fb` forced 0 after a set → `err`=1 and stays 1. Pulse `err_clr` → `err`=0. Pulse `err_clr` together with a new mismatch → `err` stays 1.
- Back-to-back clear, set with `req_valid` held high → each code is held 2 cycles with at least one `rs`=0 cycle between them. `rs`=3 is never observed.
- Assert `rst` during DRIVE → `rs`=0 asynchronously, no `done`, and the next toggle resolves to set.
- Nop request → `rs` stays 0, `done` pulses 1 cycle later, `exp_q` is unchanged.
